// File: rtl/tile_load_pkg.sv
// Shared tile geometry, derived index widths and the loader state encoding.
package tile_load_pkg;

    localparam int unsigned IO_DATA_WIDTH = 16;
    localparam int unsigned TILE_WIDTH    = 64;
    localparam int unsigned TILE_HEIGHT   = 128;
    localparam int unsigned TILE_CHANNELS = 2;
    localparam int unsigned KERNEL_WORDS  = 512;
    localparam int unsigned OVERLAP_WORDS = TILE_CHANNELS * TILE_HEIGHT;
    localparam int unsigned INPUT_WORDS   = TILE_CHANNELS * TILE_HEIGHT * TILE_WIDTH;

    localparam int unsigned X_W    = $clog2(TILE_WIDTH);
    localparam int unsigned Y_W    = $clog2(TILE_HEIGHT);
    localparam int unsigned CH_W   = $clog2(TILE_CHANNELS);
    localparam int unsigned IN_W   = CH_W + Y_W + X_W;
    localparam int unsigned K_W    = $clog2(KERNEL_WORDS);
    localparam int unsigned O_W    = $clog2(OVERLAP_WORDS);
    localparam int unsigned ROWS_W = Y_W + 1;

    // Address bit that steers a write into kernel memory instead of input memory.
    localparam int unsigned KSEL_BIT = IO_DATA_WIDTH - 1;

    function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
        return (a > b) ? a : b;
    endfunction

    // One counter serves every phase, so it is sized for the largest one.
    localparam int unsigned CNT_W = max_u(IN_W, max_u(K_W, O_W));

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        KERNEL  = 3'd1,
        INPUT   = 3'd2,
        OVERLAP = 3'd3,
        READY   = 3'd4
    } state_e;

endpackage

// File: rtl/load_addr_gen.sv
// Phase counter for the tile loader: {ch, y, x} index, last-beat flags and zero-row decision.
module load_addr_gen
    import tile_load_pkg::*;
(
    input  logic              clk,
    input  logic              arst_n_in,
    input  logic              start_i,
    input  logic [ROWS_W-1:0] rows_i,
    input  logic              clr_i,
    input  logic              adv_i,
    output logic [CH_W-1:0]   ch_o,
    output logic [Y_W-1:0]    y_o,
    output logic [X_W-1:0]    x_o,
    output logic              last_kernel_o,
    output logic              last_input_o,
    output logic              last_overlap_o,
    output logic              zero_row_o
);

    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [ROWS_W-1:0] rows_q, rows_d;
    logic [Y_W-1:0]    y_d;
    logic              last_kernel_q, last_kernel_d;
    logic              last_input_q, last_input_d;
    logic              last_overlap_q, last_overlap_d;
    logic              zero_row_q, zero_row_d;

    // Next count, clamped row limit, and flags precomputed so they are registered.
    always_comb begin
        cnt_d  = cnt_q;
        rows_d = rows_q;
        if (start_i) begin
            rows_d = (rows_i > ROWS_W'(TILE_HEIGHT)) ? ROWS_W'(TILE_HEIGHT) : rows_i;
        end
        if (clr_i) begin
            cnt_d = '0;
        end else if (adv_i) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
        y_d            = cnt_d[X_W +: Y_W];
        last_kernel_d  = (cnt_d == CNT_W'(KERNEL_WORDS - 1));
        last_input_d   = (cnt_d == CNT_W'(INPUT_WORDS - 1));
        last_overlap_d = (cnt_d == CNT_W'(OVERLAP_WORDS - 1));
        zero_row_d     = (ROWS_W'(y_d) >= rows_d);
    end

    // Counter, row limit and flag registers.
    always_ff @(posedge clk or negedge arst_n_in) begin
        if (!arst_n_in) begin
            cnt_q          <= '0;
            rows_q         <= '0;
            last_kernel_q  <= 1'b0;
            last_input_q   <= 1'b0;
            last_overlap_q <= 1'b0;
            zero_row_q     <= 1'b0;
        end else begin
            cnt_q          <= cnt_d;
            rows_q         <= rows_d;
            last_kernel_q  <= last_kernel_d;
            last_input_q   <= last_input_d;
            last_overlap_q <= last_overlap_d;
            zero_row_q     <= zero_row_d;
        end
    end

    assign x_o            = cnt_q[X_W-1:0];
    assign y_o            = cnt_q[X_W +: Y_W];
    assign ch_o           = cnt_q[X_W+Y_W +: CH_W];
    assign last_kernel_o  = last_kernel_q;
    assign last_input_o   = last_input_q;
    assign last_overlap_o = last_overlap_q;
    assign zero_row_o     = zero_row_q;

endmodule

// File: rtl/tile_load_ctrl.sv
// Sequences one tile load (kernel, input, overlap) from a word stream into the chip memories.
module tile_load_ctrl
    import tile_load_pkg::*;
(
    input  logic                     clk,
    input  logic                     arst_n_in,
    input  logic                     start_load,
    input  logic                     load_kernel,
    input  logic                     load_overlap,
    input  logic [ROWS_W-1:0]        rows_valid,
    input  logic [IO_DATA_WIDTH-1:0] s_data,
    input  logic                     s_valid,
    output logic                     s_ready,
    output logic [IO_DATA_WIDTH-1:0] mem_addr,
    output logic [IO_DATA_WIDTH-1:0] mem_din,
    output logic                     int_mem_we,
    output logic                     overlap_cache_we,
    output logic                     b_zero,
    output logic                     data_ready,
    input  logic                     fsm_done,
    output logic                     busy,
    output logic [15:0]              tiles_done
);

    state_e                   state_q, state_d;
    logic                     lo_q, lo_d;
    logic [IO_DATA_WIDTH-1:0] addr_q, addr_d;
    logic [IO_DATA_WIDTH-1:0] din_q, din_d;
    logic                     int_we_q, int_we_d;
    logic                     ov_we_q, ov_we_d;
    logic                     bz_q, bz_d;
    logic                     dr_q, dr_d;
    logic                     busy_q, busy_d;
    logic [15:0]              tiles_q, tiles_d;

    logic                     start_c, clr_c, adv_c;
    logic [CH_W-1:0]          ch;
    logic [Y_W-1:0]           y;
    logic [X_W-1:0]           x;
    logic                     last_kernel, last_input, last_overlap, zero_row;
    logic [IO_DATA_WIDTH-1:0] cnt_addr;

    load_addr_gen u_addr_gen (
        .clk            (clk),
        .arst_n_in      (arst_n_in),
        .start_i        (start_c),
        .rows_i         (rows_valid),
        .clr_i          (clr_c),
        .adv_i          (adv_c),
        .ch_o           (ch),
        .y_o            (y),
        .x_o            (x),
        .last_kernel_o  (last_kernel),
        .last_input_o   (last_input),
        .last_overlap_o (last_overlap),
        .zero_row_o     (zero_row)
    );

    assign cnt_addr = IO_DATA_WIDTH'({ch, y, x});

    // Next state, stream acceptance and the write to be issued on the next cycle.
    always_comb begin
        state_d  = state_q;
        lo_d     = lo_q;
        addr_d   = addr_q;
        din_d    = din_q;
        int_we_d = 1'b0;
        ov_we_d  = 1'b0;
        bz_d     = 1'b0;
        tiles_d  = tiles_q;
        s_ready  = 1'b0;
        start_c  = 1'b0;
        clr_c    = 1'b0;
        adv_c    = 1'b0;

        case (state_q)
            IDLE: begin
                if (start_load) begin
                    start_c = 1'b1;
                    clr_c   = 1'b1;
                    lo_d    = load_overlap;
                    state_d = load_kernel ? KERNEL : INPUT;
                end
            end
            KERNEL: begin
                s_ready = 1'b1;
                if (s_valid) begin
                    adv_c            = 1'b1;
                    int_we_d         = 1'b1;
                    din_d            = s_data;
                    addr_d           = cnt_addr;
                    addr_d[KSEL_BIT] = 1'b1;
                    if (last_kernel) begin
                        clr_c   = 1'b1;
                        state_d = INPUT;
                    end
                end
            end
            INPUT: begin
                // Rows past rows_valid are filled locally without touching the stream.
                s_ready = ~zero_row;
                if (zero_row || s_valid) begin
                    adv_c    = 1'b1;
                    int_we_d = 1'b1;
                    bz_d     = zero_row;
                    din_d    = zero_row ? '0 : s_data;
                    addr_d   = cnt_addr;
                    if (last_input) begin
                        clr_c   = 1'b1;
                        state_d = lo_q ? OVERLAP : READY;
                    end
                end
            end
            OVERLAP: begin
                s_ready = 1'b1;
                if (s_valid) begin
                    adv_c   = 1'b1;
                    ov_we_d = 1'b1;
                    din_d   = s_data;
                    addr_d  = cnt_addr;
                    if (last_overlap) begin
                        clr_c   = 1'b1;
                        state_d = READY;
                    end
                end
            end
            READY: begin
                if (fsm_done) begin
                    state_d = IDLE;
                    tiles_d = tiles_q + 16'd1;
                end
            end
            default: state_d = IDLE;
        endcase

        // data_ready trails entry to READY by one cycle, i.e. follows the final write enable.
        dr_d   = (state_q == READY) && !fsm_done;
        busy_d = (state_d != IDLE);
    end

    // State and registered output stage.
    always_ff @(posedge clk or negedge arst_n_in) begin
        if (!arst_n_in) begin
            state_q  <= IDLE;
            lo_q     <= 1'b0;
            addr_q   <= '0;
            din_q    <= '0;
            int_we_q <= 1'b0;
            ov_we_q  <= 1'b0;
            bz_q     <= 1'b0;
            dr_q     <= 1'b0;
            busy_q   <= 1'b0;
            tiles_q  <= '0;
        end else begin
            state_q  <= state_d;
            lo_q     <= lo_d;
            addr_q   <= addr_d;
            din_q    <= din_d;
            int_we_q <= int_we_d;
            ov_we_q  <= ov_we_d;
            bz_q     <= bz_d;
            dr_q     <= dr_d;
            busy_q   <= busy_d;
            tiles_q  <= tiles_d;
        end
    end

    assign mem_addr         = addr_q;
    assign mem_din          = din_q;
    assign int_mem_we       = int_we_q;
    assign overlap_cache_we = ov_we_q;
    assign b_zero           = bz_q;
    assign data_ready       = dr_q;
    assign busy             = busy_q;
    assign tiles_done       = tiles_q;

endmodule

// File: tb/tb_tile_load_ctrl.sv
// Directed bench for tile_load_ctrl: table of whole-tile loads plus handover and reset sequences.
module tb_tile_load_ctrl;

    logic        clk = 1'b0;
    logic        arst_n_in;
    logic        start_load;
    logic        load_kernel;
    logic        load_overlap;
    logic [7:0]  rows_valid;
    logic [15:0] s_data;
    logic        s_valid;
    logic        s_ready;
    logic [15:0] mem_addr;
    logic [15:0] mem_din;
    logic        int_mem_we;
    logic        overlap_cache_we;
    logic        b_zero;
    logic        data_ready;
    logic        fsm_done;
    logic        busy;
    logic [15:0] tiles_done;

    tile_load_ctrl dut (
        .clk              (clk),
        .arst_n_in        (arst_n_in),
        .start_load       (start_load),
        .load_kernel      (load_kernel),
        .load_overlap     (load_overlap),
        .rows_valid       (rows_valid),
        .s_data           (s_data),
        .s_valid          (s_valid),
        .s_ready          (s_ready),
        .mem_addr         (mem_addr),
        .mem_din          (mem_din),
        .int_mem_we       (int_mem_we),
        .overlap_cache_we (overlap_cache_we),
        .b_zero           (b_zero),
        .data_ready       (data_ready),
        .fsm_done         (fsm_done),
        .busy             (busy),
        .tiles_done       (tiles_done)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        lk;
        logic        lo;
        logic [7:0]  rows;
        logic        tog;
        int          exp_k;
        int          exp_i;
        int          exp_z;
        int          exp_o;
        int          exp_beats;
        logic [15:0] exp_fz;
    } vec_t;

    vec_t vecs[5];
    int   n_cmp = 0;
    int   n_bad = 0;
    int   exp_tiles = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Drive one complete tile load and score every write against an address/data model.
    task automatic run_load(input int vi);
        vec_t        v;
        int          kw, rows_eff, n, kc, ic, zc, oc, beats, errs, cyc, last_we, dr_at, m, yy;
        logic [15:0] fz, exp_addr, word;
        logic        exp_bz, exp_ov, pend;
        logic [15:0] q[$];
        v        = vecs[vi];
        kw       = v.lk ? 512 : 0;
        rows_eff = (int'(v.rows) > 128) ? 128 : int'(v.rows);
        n = 0; kc = 0; ic = 0; zc = 0; oc = 0; beats = 0; errs = 0; cyc = 0;
        last_we = -1; dr_at = -1; fz = 16'hFFFF;

        start_load   = 1'b1;
        load_kernel  = v.lk;
        load_overlap = v.lo;
        rows_valid   = v.rows;
        @(negedge clk);
        start_load   = 1'b0;
        load_kernel  = ~v.lk;
        load_overlap = ~v.lo;
        rows_valid   = 8'd7;
        check($sformatf("v%0d busy_start", vi), 32'(busy), 32'd1);

        while (dr_at < 0 && cyc < 40000) begin
            s_valid = v.tog ? (cyc % 2 == 0) : 1'b1;
            s_data  = 16'(cyc * 97) ^ 16'hC3A5;
            pend    = s_valid & s_ready;
            if (pend) begin
                q.push_back(s_data);
                beats++;
            end
            @(negedge clk);
            cyc++;
            if (data_ready && dr_at < 0) dr_at = cyc;
            if (int_mem_we || overlap_cache_we) begin
                last_we = cyc;
                if (overlap_cache_we) oc++;
                else if (b_zero) begin
                    zc++;
                    if (fz == 16'hFFFF) fz = mem_addr;
                end
                else if (mem_addr[15]) kc++;
                else ic++;

                exp_bz = 1'b0;
                exp_ov = 1'b0;
                if (n < kw) begin
                    exp_addr = 16'h8000 | 16'(n);
                end else if (n < kw + 16384) begin
                    m        = n - kw;
                    yy       = (m >> 6) & 127;
                    exp_addr = 16'(m);
                    exp_bz   = (yy >= rows_eff);
                end else begin
                    m        = n - kw - 16384;
                    exp_addr = 16'(m);
                    exp_ov   = 1'b1;
                    if (!v.lo || m >= 256) errs++;
                end
                if (mem_addr !== exp_addr || b_zero !== exp_bz ||
                    overlap_cache_we !== exp_ov || int_mem_we !== ~exp_ov) errs++;
                if (!exp_bz) begin
                    if (!pend || q.size() == 0) errs++;
                    else begin
                        word = q.pop_front();
                        if (mem_din !== word) errs++;
                    end
                end else if (pend) errs++;
                n++;
            end else if (pend) errs++;
            if (b_zero && !int_mem_we) errs++;
        end
        s_valid = 1'b0;
        if (q.size() != 0) errs++;

        check($sformatf("v%0d kernel_writes", vi), 32'(kc), 32'(v.exp_k));
        check($sformatf("v%0d input_writes", vi), 32'(ic), 32'(v.exp_i));
        check($sformatf("v%0d zero_writes", vi), 32'(zc), 32'(v.exp_z));
        check($sformatf("v%0d overlap_writes", vi), 32'(oc), 32'(v.exp_o));
        check($sformatf("v%0d beats", vi), 32'(beats), 32'(v.exp_beats));
        check($sformatf("v%0d first_zero_addr", vi), 32'(fz), 32'(v.exp_fz));
        check($sformatf("v%0d seq_errors", vi), 32'(errs), 32'd0);
        check($sformatf("v%0d dr_latency", vi), 32'(dr_at - last_we), 32'd1);
    endtask

    // READY holds against a new start_load; fsm_done releases it and counts the tile.
    task automatic handover(input int vi);
        s_valid      = 1'b1;
        start_load   = 1'b1;
        load_kernel  = 1'b1;
        load_overlap = 1'b1;
        rows_valid   = 8'd128;
        @(negedge clk);
        start_load = 1'b0;
        @(negedge clk);
        check($sformatf("v%0d ready_hold", vi),
              32'({data_ready, busy, s_ready, int_mem_we, overlap_cache_we}), 32'b11000);
        s_valid  = 1'b0;
        fsm_done = 1'b1;
        @(negedge clk);
        fsm_done = 1'b0;
        exp_tiles++;
        check($sformatf("v%0d dr_fall", vi), 32'(data_ready), 32'd0);
        check($sformatf("v%0d busy_fall", vi), 32'(busy), 32'd0);
        check($sformatf("v%0d tiles_inc", vi), 32'(tiles_done), 32'(exp_tiles));
        fsm_done = 1'b1;
        @(negedge clk);
        fsm_done = 1'b0;
        @(negedge clk);
        check($sformatf("v%0d done_in_idle", vi), 32'({busy, tiles_done}), 32'(exp_tiles));
    endtask

    initial begin
        int          kc, cyc;
        logic [15:0] d0;

        arst_n_in    = 1'b0;
        start_load   = 1'b0;
        load_kernel  = 1'b0;
        load_overlap = 1'b0;
        rows_valid   = 8'd0;
        s_data       = 16'd0;
        s_valid      = 1'b0;
        fsm_done     = 1'b0;

        vecs[0] = '{1'b1, 1'b1, 8'd128, 1'b0,  512, 16384,     0, 256, 17152, 16'hFFFF};
        vecs[1] = '{1'b0, 1'b0, 8'd100, 1'b0,    0, 12800,  3584,   0, 12800, 16'h1900};
        vecs[2] = '{1'b0, 1'b1, 8'd0,   1'b0,    0,     0, 16384, 256,   256, 16'h0000};
        vecs[3] = '{1'b0, 1'b0, 8'd3,   1'b1,    0,   384, 16000,   0,   384, 16'h00C0};
        vecs[4] = '{1'b0, 1'b0, 8'd200, 1'b0,    0, 16384,     0,   0, 16384, 16'hFFFF};

        #12;
        check("reset_ctl", 32'({s_ready, int_mem_we, overlap_cache_we, b_zero, data_ready, busy}), 32'd0);
        check("reset_addr", 32'(mem_addr), 32'd0);
        check("reset_tiles", 32'(tiles_done), 32'd0);
        @(negedge clk);
        arst_n_in = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 5; i++) begin
            run_load(i);
            handover(i);
        end

        // Reset in the middle of a kernel load, then restart from kernel address 0.
        start_load   = 1'b1;
        load_kernel  = 1'b1;
        load_overlap = 1'b1;
        rows_valid   = 8'd128;
        @(negedge clk);
        start_load = 1'b0;
        kc  = 0;
        cyc = 0;
        while (kc < 300 && cyc < 2000) begin
            s_valid = 1'b1;
            s_data  = 16'(cyc * 13) ^ 16'h7E01;
            @(negedge clk);
            cyc++;
            if (int_mem_we) kc++;
        end
        check("rst_pre_writes", 32'(kc), 32'd300);
        #2 arst_n_in = 1'b0;
        #1;
        check("rst_ctl", 32'({s_ready, int_mem_we, overlap_cache_we, b_zero, data_ready, busy}), 32'd0);
        check("rst_addr", 32'(mem_addr), 32'd0);
        check("rst_din", 32'(mem_din), 32'd0);
        check("rst_tiles", 32'(tiles_done), 32'd0);
        @(negedge clk);
        @(negedge clk);
        arst_n_in = 1'b1;
        @(negedge clk);
        check("rst_idle", 32'({busy, s_ready, int_mem_we, overlap_cache_we}), 32'd0);
        s_valid      = 1'b0;
        start_load   = 1'b1;
        load_kernel  = 1'b1;
        load_overlap = 1'b0;
        @(negedge clk);
        start_load = 1'b0;
        d0         = 16'hBEEF;
        s_data     = d0;
        s_valid    = 1'b1;
        @(negedge clk);
        s_valid = 1'b0;
        check("restart_we", 32'(int_mem_we), 32'd1);
        check("restart_addr", 32'(mem_addr), 32'h8000);
        check("restart_din", 32'(mem_din), 32'(d0));
        @(negedge clk);
        check("restart_stall", 32'({int_mem_we, overlap_cache_we}), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/tile_load_ctrl.md
Name: tile_load_ctrl

Overview:
- Sequences the loading of one convolution tile into the chip's on-chip memories: kernel memory, input memory and overlap cache.
- Consumes a single valid/ready word stream and generates the write address, write data and write enables (int_mem_we, overlap_cache_we, b_zero) that the chip top expects.
- Raises data_ready to the convolution controller once the tile is resident, then holds it until that controller reports fsm_done.
- Sits between the host stream and the chip's a_input/b_input/write-enable pins.

Parameters:
- IO_DATA_WIDTH, 16, width of stream words and memory data.
- TILE_WIDTH, 64, x positions per row (power of 2).
- TILE_HEIGHT, 128, rows per channel (power of 2).
- TILE_CHANNELS, 2, input channels per tile (power of 2).
- KERNEL_WORDS, 512, kernel memory words loaded per kernel load.
- OVERLAP_WORDS, 256, overlap cache words (TILE_CHANNELS*TILE_HEIGHT).

Ports:
- clk  in  1  clock
- arst_n_in  in  1  asynchronous reset, active low
- start_load  in  1  pulse; begins a tile load when idle
- load_kernel  in  1  sampled at start_load; 1 = reload kernel memory first
- load_overlap  in  1  sampled at start_load; 1 = load overlap cache after input
- rows_valid  in  $clog2(TILE_HEIGHT)+1  sampled at start_load; rows >= this value are zero-filled
- s_data  in  IO_DATA_WIDTH  stream word
- s_valid  in  1  stream word valid
- s_ready  out  1  stream word accepted when s_valid & s_ready
- mem_addr  out  IO_DATA_WIDTH  drives a_input; bit 15 = kernel select
- mem_din  out  IO_DATA_WIDTH  drives b_input
- int_mem_we  out  1  input/kernel memory write
- overlap_cache_we  out  1  overlap cache write
- b_zero  out  1  forces written data to zero (input memory only)
- data_ready  out  1  tile resident; level signal to the convolution controller
- fsm_done  in  1  convolution controller finished the tile
- busy  out  1  not IDLE
- tiles_done  out  16  count of completed tiles; wraps at 2^16

Behaviour:
- Reset: every output is 0, state IDLE, all counters 0. Assertion mid-load aborts immediately and no further write is issued; memory contents are left as-is.
- FSM: IDLE -> (start_load) KERNEL if load_kernel, else INPUT. KERNEL -> INPUT. INPUT -> OVERLAP if load_overlap, else READY. OVERLAP -> READY. READY -> (fsm_done) IDLE.
- start_load outside IDLE is ignored. fsm_done outside READY is ignored.
- KERNEL:
  - s_ready=1.
  - Accept index k = 0..KERNEL_WORDS-1.
  - mem_addr = {1'b1, zeros, k}.
- INPUT: linear index i = {ch, y, x}, x fastest, then y, then ch; TILE_CHANNELS*TILE_HEIGHT*TILE_WIDTH words.
  - y < rows_valid: s_ready=1; write only on handshake, with mem_din = s_data and b_zero = 0.
  - y >= rows_valid: s_ready=0; one zero write per cycle with b_zero=1, no stream consumption.
  - mem_addr = {1'b0, zeros, ch, y, x}.
  - rows_valid=0 means a whole tile of zeros. rows_valid > TILE_HEIGHT is clamped to TILE_HEIGHT.
- OVERLAP:
  - s_ready=1.
  - index o = {ch, y}.
  - mem_addr = {zeros, o}, overlap_cache_we=1, int_mem_we=0.
- Write timing: address, data and enable outputs are registered. A beat accepted (or a zero slot) at cycle t produces the write at cycle t+1, with the enable held for exactly 1 cycle.
- s_valid low stalls the load with no write. Back-to-back beats give one write per cycle.
- Phase change: the last beat of a phase moves the state in the same cycle. The next phase's first beat may be accepted in the following cycle; there are no idle gaps.
- data_ready rises in the cycle after the final write's enable.
- In READY, s_ready=0. fsm_done deasserts data_ready in the next cycle and increments tiles_done.
- s_ready is combinational from state and counters only, never from s_valid.

Decomposition:
- Package tile_load_pkg holds:
  - state enum (IDLE, KERNEL, INPUT, OVERLAP, READY);
  - localparams for the index widths (derived via $clog2) and the kernel-select bit position.
- One natural sub-module: load_addr_gen, which holds the phase counters and produces {ch, y, x}, the last-beat flags and the zero-row decision.

Test Plan:
- Full load: start_load with load_kernel=1, load_overlap=1, rows_valid=128, continuous s_valid.
  - Exactly 512 kernel writes with addr bit15=1, then 16384 input writes, then 256 overlap writes.
  - data_ready rises 1 cycle after the last write; 17152 data-carrying beats consumed in total.
- Zero rows: load_kernel=0, load_overlap=0, rows_valid=100.
  - Rows 100..127 of each channel are written with b_zero=1 and s_ready=0.
  - Exactly 2*100*64=12800 beats consumed.
  - First zero write at addr 0x1900 (ch0, y100, x0).
- Backpressure: s_valid toggled 1,0,1,0 during INPUT.
  - Writes occur only 1 cycle after each handshake; addresses are contiguous with no skips or duplicates.
- Handover: in READY, pulse fsm_done.
  - data_ready goes 0 next cycle, tiles_done goes 0->1, busy goes 0.
  - start_load during the READY state has no effect.
- Reset mid-operation: assert arst_n_in after 300 kernel writes.
  - All outputs go 0 immediately and state is IDLE.
  - A fresh start_load restarts at kernel address 0.
- rows_valid=0 with load_overlap=1: 16384 zero writes, s_ready=0 throughout INPUT, then 256 overlap beats consumed.
